// File: rtl/icache_assoc_if.sv
// CPU fetch handshake plus block-wide instruction-memory port of the cache.
// master: the CPU/memory side that drives requests; slave: the cache itself.
interface icache_assoc_if #(
    parameter int WORDS  = 4,
    parameter int ADDR_W = 10
);
    localparam int OFF  = 2 + $clog2(WORDS);
    localparam int MA_W = ADDR_W - OFF;

    logic [31:0]         address;
    logic                flush;
    logic                busywait;
    logic [31:0]         instruction;
    logic                mem_read;
    logic [MA_W-1:0]     mem_address;
    logic [32*WORDS-1:0] mem_readdata;
    logic                mem_busywait;

    modport master (
        output address, flush, mem_readdata, mem_busywait,
        input  busywait, instruction, mem_read, mem_address
    );

    modport slave (
        input  address, flush, mem_readdata, mem_busywait,
        output busywait, instruction, mem_read, mem_address
    );
endinterface

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with LRU replacement and flush.
// Latency: hits return in the same cycle; a miss stalls L+3 cycles for memory stall L.
// Backpressure: busywait holds the CPU; mem_busywait stretches the refill read.
module icache_assoc #(
    parameter int WAYS   = 2,
    parameter int SETS   = 8,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         reset,
    icache_assoc_if.slave bus
);
    localparam int OFF    = 2 + $clog2(WORDS);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG    = ADDR_W - OFF - IDX;
    localparam int MA_W   = ADDR_W - OFF;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEM_READ = 2'd1;
    localparam logic [1:0] UPDATE   = 2'd2;

    logic [1:0]              state;
    logic [MA_W-1:0]         ma_q;
    logic [WAY_W-1:0]        victim_q;
    logic                    flush_pend;
    logic [SETS-1:0][WAYS-1:0] valid;
    logic [TAG-1:0]          tags [SETS][WAYS];
    logic [32*WORDS-1:0]     data [SETS][WAYS];

    logic [IDX-1:0]          idx;
    logic [IDX-1:0]          ref_idx;
    logic [TAG-1:0]          tag_in;
    logic [TAG-1:0]          ref_tag;
    logic [WSEL_W-1:0]       word_off;
    logic                    hit;
    logic [WAY_W-1:0]        hit_way;
    logic [WAY_W-1:0]        victim;
    logic [WAY_W-1:0]        age_victim;
    logic [32*WORDS-1:0]     blk;
    logic [31:0]             instr;
    logic                    refill_we;

    assign idx      = IDX'(bus.address >> OFF);
    assign tag_in   = TAG'(bus.address >> (OFF + IDX));
    assign word_off = WSEL_W'(bus.address >> 2);
    // The latched block address carries the refill set and tag, so a moving PC cannot redirect it.
    assign ref_idx  = ma_q[IDX-1:0];
    assign ref_tag  = ma_q[MA_W-1:IDX];

    assign refill_we = (state == MEM_READ) && !bus.mem_busywait;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && (tags[idx][w] == tag_in)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        blk   = data[idx][hit_way];
        instr = '0;
        if (hit) begin
            for (int w = 0; w < WORDS; w++) begin
                if ((WORDS == 1) || (WSEL_W'(w) == word_off)) begin
                    instr = blk[32*w +: 32];
                end
            end
        end
    end

    // Lowest invalid way wins; otherwise fall back to the oldest way of the set.
    always_comb begin
        victim = age_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    assign bus.busywait    = reset && ((state != IDLE) || !hit);
    assign bus.instruction = instr;
    assign bus.mem_read    = (state == MEM_READ);
    assign bus.mem_address = ma_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ma_q       <= '0;
            victim_q   <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        state    <= MEM_READ;
                        ma_q     <= MA_W'(bus.address >> OFF);
                        victim_q <= victim;
                    end
                end
                MEM_READ: begin
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (!bus.mem_busywait) begin
                        state      <= UPDATE;
                        flush_pend <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if ((state == IDLE) && bus.flush) begin
            valid <= '0;
        end else if (refill_we) begin
            if (flush_pend || bus.flush) begin
                valid <= '0;
            end
            valid[ref_idx][victim_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (refill_we) begin
            data[ref_idx][victim_q] <= bus.mem_readdata;
            tags[ref_idx][victim_q] <= ref_tag;
        end
    end

    generate
        if (WAYS > 1) begin : g_lru
            logic [WAY_W-1:0] ages [SETS][WAYS];
            logic             upd_en;
            logic [IDX-1:0]   upd_set;
            logic [WAY_W-1:0] upd_way;
            logic [WAY_W-1:0] upd_age;

            // A hit in IDLE and a refill write never coincide, so one update port serves both.
            always_comb begin
                upd_en  = 1'b0;
                upd_set = idx;
                upd_way = hit_way;
                if ((state == IDLE) && hit && !bus.flush) begin
                    upd_en = 1'b1;
                end else if (refill_we) begin
                    upd_en  = 1'b1;
                    upd_set = ref_idx;
                    upd_way = victim_q;
                end
                upd_age = ages[upd_set][upd_way];
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            ages[s][w] <= WAY_W'(w);
                        end
                    end
                end else if (upd_en) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == upd_way) begin
                            ages[upd_set][w] <= '0;
                        end else if (ages[upd_set][w] < upd_age) begin
                            ages[upd_set][w] <= ages[upd_set][w] + 1'b1;
                        end
                    end
                end
            end

            always_comb begin
                age_victim = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (ages[idx][w] == WAY_W'(WAYS - 1)) begin
                        age_victim = WAY_W'(w);
                    end
                end
            end
        end else begin : g_dm
            assign age_victim = '0;
        end
    endgenerate
endmodule
